ctrl_playback: RTL and testbench

Scripted controller-input sequencer for the NES simulation benches and the on-board self-test. It holds a small script of (duration, player-1 buttons, player-2 buttons) entries and replays it one entry per N video frames. Its button outputs drive the `btns` inputs of the two `controller_sim` instances. Button changes are deferred while the controller strobe is high, so the game never latches a half-updated state.

---
 rtl/ctrl_playback.sv | 150 +++++++++++++++
 tb/tb_ctrl_playback.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_playback.sv
// Scripted controller-input sequencer: replays (frames, btns1, btns0) entries.
// Optional CTRL_PLAYBACK_LOOP_EN restarts the script at its terminator.
module ctrl_playback #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          ctrl_strobe,
  input  logic          start,
  input  logic          stop,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  output logic [7:0]    btns0,
  output logic [7:0]    btns1,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] entry_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  state_t        state, state_d;
  logic [AW-1:0] idx_d;
  logic [7:0]    b0_d, b1_d;
  logic [7:0]    cnt, cnt_d;
  logic          tick_pend, pend_d;
  logic          wr_ok;

  logic [23:0]   mem [2**AW];
  logic [23:0]   rd_data;
  logic [7:0]    rd_cnt;

  assign wr_ok  = wr_en && (state == S_IDLE || state == S_DONE);
  assign rd_cnt = rd_data[23:16];
  assign busy   = (state == S_FETCH) || (state == S_APPLY)
               || (state == S_HOLD);
  assign done   = (state == S_DONE);

  // Read address is the next index, so data for entry_idx is ready in FETCH.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_addr] <= wr_data;
    rd_data <= mem[idx_d];
  end

  always_comb begin
    state_d = state;
    idx_d   = entry_idx;
    b0_d    = btns0;
    b1_d    = btns1;
    cnt_d   = cnt;
    pend_d  = tick_pend;
    if (stop) begin
      state_d = S_IDLE;
      idx_d   = '0;
      b0_d    = '0;
      b1_d    = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            idx_d   = '0;
          end
        end
        S_FETCH: begin
          if (frame_tick)
            pend_d = 1'b1;
          if (rd_cnt == 8'd0) begin
`ifdef CTRL_PLAYBACK_LOOP_EN
            if (entry_idx != '0) begin
              idx_d = '0;
            end else begin
              state_d = S_DONE;
              b0_d    = '0;
              b1_d    = '0;
              pend_d  = 1'b0;
            end
`else
            state_d = S_DONE;
            b0_d    = '0;
            b1_d    = '0;
            pend_d  = 1'b0;
`endif
          end else begin
            state_d = S_APPLY;
          end
        end
        S_APPLY: begin
          if (frame_tick)
            pend_d = 1'b1;
          if (!ctrl_strobe) begin
            b0_d    = rd_data[7:0];
            b1_d    = rd_data[15:8];
            cnt_d   = rd_cnt;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          pend_d = 1'b0;
          if (frame_tick || tick_pend) begin
            cnt_d = cnt - 8'd1;
            if (cnt == 8'd1) begin
              idx_d   = entry_idx + IDX_ONE;
              state_d = S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_FETCH;
            idx_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      entry_idx <= '0;
      btns0     <= '0;
      btns1     <= '0;
      cnt       <= '0;
      tick_pend <= 1'b0;
    end else begin
      state     <= state_d;
      entry_idx <= idx_d;
      btns0     <= b0_d;
      btns1     <= b1_d;
      cnt       <= cnt_d;
      tick_pend <= pend_d;
    end
  end

endmodule

// File: tb/tb_ctrl_playback.sv
// Scoreboard bench for ctrl_playback: expected output changes are queued
// with their edge number; a negedge monitor pops and compares.
module tb_ctrl_playback;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          ctrl_strobe = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic [7:0]    btns0, btns1;
  logic          busy, done;
  logic [AW-1:0] entry_idx;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    int          c;
    logic [17:0] v;
  } ev_t;

  ev_t         q[$];
  logic [17:0] last = '0;

  ctrl_playback #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .ctrl_strobe(ctrl_strobe),
    .start      (start),
    .stop       (stop),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .btns0      (btns0),
    .btns1      (btns1),
    .busy       (busy),
    .done       (done),
    .entry_idx  (entry_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [17:0] cur;
    ev_t         e;
    cur = {done, busy, btns1, btns0};
    if (cur !== last) begin
      n_run++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc %0d got %h", cyc, cur);
      end else begin
        e = q.pop_front();
        if (e.v !== cur || e.c != cyc) begin
          n_fail++;
          $display("FAIL event got %h at %0d, expected %h at %0d",
                   cur, cyc, e.v, e.c);
        end
      end
      last = cur;
    end
  end

  function automatic void push(int c, logic d, logic b,
                               logic [7:0] p1, logic [7:0] p0);
    ev_t e;
    e.c = c;
    e.v = {d, b, p1, p0};
    q.push_back(e);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic wr(logic [AW-1:0] a, logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic tick(output int e);
    e = cyc + 1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic go_start();
    push(cyc + 1, 1'b0, 1'b1, 8'h00, 8'h00);
    push(cyc + 3, 1'b0, 1'b1, 8'h00, 8'h08);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    int e;
    int e2;
    repeat (3) step();
    chk("rst_btns0", 32'(btns0), 32'h0);
    chk("rst_btns1", 32'(btns1), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_idx", 32'(entry_idx), 32'h0);
    rst_n = 1'b1;
    step();

    wr(6'd0, {8'd3, 8'h00, 8'h08});
    wr(6'd1, {8'd2, 8'h00, 8'h01});
    wr(6'd2, 24'h0);

    // basic playback, ticks every 100 cycles
    go_start();
    idle(100);
    tick(e); idle(99);
    tick(e); idle(99);
    tick(e);
    push(e + 2, 1'b0, 1'b1, 8'h00, 8'h01);
    idle(5);
    chk("s1_idx1", 32'(entry_idx), 32'd1);
    idle(94);
    tick(e); idle(99);
    tick(e);
    push(e + 1, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(5);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_busy", 32'(busy), 32'd0);

    // strobe high across an entry advance
    go_start();
    idle(50);
    tick(e); idle(50);
    tick(e); idle(50);
    ctrl_strobe = 1'b1;
    step();
    tick(e);
    idle(10);
    push(cyc + 1, 1'b0, 1'b1, 8'h00, 8'h01);
    ctrl_strobe = 1'b0;
    step();
    idle(50);
    tick(e); idle(50);
    tick(e);
    push(e + 1, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(20);

    // tick while in FETCH is carried into HOLD
    go_start();
    idle(50);
    tick(e); idle(50);
    tick(e); idle(50);
    tick(e);
    push(e + 2, 1'b0, 1'b1, 8'h00, 8'h01);
    tick(e2);
    idle(50);
    tick(e);
    push(e + 1, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(20);

    // stop+start mid-HOLD, write drop during HOLD, write accepted in IDLE
    go_start();
    idle(20);
    wr(6'd0, {8'd1, 8'h00, 8'h40});
    idle(5);
    push(cyc + 1, 1'b0, 1'b0, 8'h00, 8'h00);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("stop_idx", 32'(entry_idx), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    wr(6'd1, {8'd1, 8'h00, 8'h20});
    go_start();
    idle(50);
    tick(e); idle(50);
    tick(e); idle(50);
    tick(e);
    push(e + 2, 1'b0, 1'b1, 8'h00, 8'h20);
    idle(50);
    tick(e);
    push(e + 1, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(20);

    // async reset during entry 1, then replay
    go_start();
    idle(50);
    tick(e); idle(50);
    tick(e); idle(50);
    tick(e);
    push(e + 2, 1'b0, 1'b1, 8'h00, 8'h20);
    idle(20);
    chk("pre_rst_idx", 32'(entry_idx), 32'd1);
    push(cyc, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("arst_btns0", 32'(btns0), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_idx", 32'(entry_idx), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    go_start();
    idle(50);
    tick(e); idle(50);
    tick(e); idle(50);
    tick(e);
    push(e + 2, 1'b0, 1'b1, 8'h00, 8'h20);
    idle(50);
    tick(e);
    push(e + 1, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(20);

`ifdef CTRL_PLAYBACK_LOOP_EN
    push(cyc + 1, 1'b0, 1'b0, 8'h00, 8'h00);
    pulse_stop();
    wr(6'd0, {8'd1, 8'h00, 8'h80});
    wr(6'd1, 24'h0);
    push(cyc + 1, 1'b0, 1'b1, 8'h00, 8'h00);
    push(cyc + 3, 1'b0, 1'b1, 8'h00, 8'h80);
    start = 1'b1;
    step();
    start = 1'b0;
    idle(50);
    repeat (4) begin
      tick(e);
      idle(50);
    end
    chk("loop_done", 32'(done), 32'd0);
    chk("loop_busy", 32'(busy), 32'd1);
    chk("loop_btns0", 32'(btns0), 32'h80);
    push(cyc + 1, 1'b0, 1'b0, 8'h00, 8'h00);
    pulse_stop();
`else
    push(cyc + 1, 1'b0, 1'b0, 8'h00, 8'h00);
    pulse_stop();
`endif

    // entry-0 terminator goes straight to DONE
    wr(6'd0, 24'h0);
    push(cyc + 1, 1'b0, 1'b1, 8'h00, 8'h00);
    push(cyc + 2, 1'b1, 1'b0, 8'h00, 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    idle(10);
    chk("t0_done", 32'(done), 32'd1);

    while (q.size() != 0) begin
      ev_t m;
      m = q.pop_front();
      n_run++;
      n_fail++;
      $display("FAIL missing_event expected %h at %0d", m.v, m.c);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
